// File: rtl/rs_pkg.sv
// Shared GF(256) definitions for the RS syndrome front end: field constants,
// FSM state type and elaboration-time field arithmetic helpers.
package rs_pkg;

    localparam int          GF_W    = 8;
    localparam logic [7:0]  GF_POLY = 8'h1D;   // x^8+x^4+x^3+x^2+1 with x^8 implied
    localparam int          N_MAX   = 255;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACC  = 1'b1
    } rs_state_e;

    // Shift-and-add multiply, reducing by GF_POLY whenever x^8 appears.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        logic [7:0] x;
        r = '0;
        x = a;
        for (int i = 0; i < GF_W; i++) begin
            if (b[i]) r ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? GF_POLY : 8'h00);
        end
        return r;
    endfunction

    function automatic logic [7:0] gf_alpha_pow(input int e);
        int         m;
        logic [7:0] r;
        m = e % 255;
        if (m < 0) m += 255;
        r = 8'h01;
        for (int i = 0; i < 255; i++) begin
            if (i < m) r = gf_mul(r, 8'h02);
        end
        return r;
    endfunction

endpackage

// File: rtl/gf_const_mul.sv
// Combinational GF(256) multiply by a constant: each input bit selects one
// precomputed column, so the result is a pure XOR network.
module gf_const_mul
    import rs_pkg::*;
#(
    parameter logic [7:0] CONST = 8'h02
) (
    input  logic [7:0] a_i,
    output logic [7:0] y_o
);

    logic [7:0] term [8];

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_col
            localparam logic [7:0] COL = gf_mul(CONST, 8'(1 << gi));
            assign term[gi] = {8{a_i[gi]}} & COL;
        end
    endgenerate

    always_comb begin
        y_o = '0;
        for (int i = 0; i < 8; i++) y_o ^= term[i];
    end

endmodule

// File: rtl/rs_syndrome_par.sv
// Parametrised RS syndrome generator over GF(256) with a valid/ready output buffer.
// Optional length check (len_err output) is enabled by defining RS_LEN_CHECK_EN.
module rs_syndrome_par #(
    parameter int NSYM  = 8,
    parameter int FCR   = 1,
    parameter int N_MAX = rs_pkg::N_MAX
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              din_val,
    input  logic              din_sop,
    input  logic              din_eop,
    input  logic [7:0]        din,
    output logic              synd_val,
    input  logic              synd_rdy,
    output logic [NSYM*8-1:0] synd,
    output logic              synd_zero,
    output logic [8:0]        cw_len,
`ifdef RS_LEN_CHECK_EN
    output logic              len_err,
`endif
    output logic              busy,
    output logic              frame_err,
    output logic              overrun
);
    import rs_pkg::*;

    localparam int SW = NSYM * 8;

    rs_state_e   state_q, state_d;
    logic [SW-1:0] acc_q, acc_d;
    logic [8:0]  len_q, len_d;
    logic [SW-1:0] synd_q, synd_d;
    logic        synd_val_q, synd_val_d;
    logic        synd_zero_q, synd_zero_d;
    logic [8:0]  cw_len_q, cw_len_d;
    logic        frame_err_q, frame_err_d;
    logic        overrun_q, overrun_d;
`ifdef RS_LEN_CHECK_EN
    logic        len_err_q, len_err_d;
    logic        fin_len_err;
`endif

    logic [SW-1:0] mul_out;
    logic [SW-1:0] horner;
    logic [SW-1:0] fin_synd;
    logic [8:0]    len_inc;
    logic [8:0]    fin_len;
    logic          in_acc, sop_hit, acc_hit, finalise, buf_free, fin_zero;

    // One Horner step per syndrome: acc_j * alpha^(FCR+j-1) ^ din.
    genvar gi;
    generate
        for (gi = 0; gi < NSYM; gi++) begin : g_synd
            localparam logic [7:0] ROOT = gf_alpha_pow(FCR + gi);
            gf_const_mul #(.CONST(ROOT)) u_mul (
                .a_i (acc_q[gi*8 +: 8]),
                .y_o (mul_out[gi*8 +: 8])
            );
            assign horner[gi*8 +: 8] = mul_out[gi*8 +: 8] ^ din;
        end
    endgenerate

    always_comb begin
        in_acc   = (state_q == ST_ACC);
        sop_hit  = din_val & din_sop;
        acc_hit  = din_val & in_acc & ~din_sop;
        finalise = din_val & din_eop & (din_sop | in_acc);
        buf_free = ~synd_val_q | synd_rdy;

        len_inc  = (len_q == 9'd511) ? 9'd511 : len_q + 9'd1;
        fin_len  = din_sop ? 9'd1 : len_inc;
        fin_synd = din_sop ? {NSYM{din}} : horner;
`ifdef RS_LEN_CHECK_EN
        fin_len_err = (fin_len > 9'(N_MAX)) || (fin_len < 9'(NSYM + 1));
        fin_zero    = (fin_synd == '0) & ~fin_len_err;
`else
        fin_zero    = (fin_synd == '0);
`endif

        state_d = state_q;
        if (sop_hit)               state_d = din_eop ? ST_IDLE : ST_ACC;
        else if (acc_hit & din_eop) state_d = ST_IDLE;

        acc_d = acc_q;
        len_d = len_q;
        if (sop_hit) begin
            acc_d = {NSYM{din}};
            len_d = 9'd1;
        end else if (acc_hit) begin
            acc_d = horner;
            len_d = len_inc;
        end

        // A held result is only replaced when it is leaving this cycle or already gone.
        synd_val_d  = synd_val_q & ~synd_rdy;
        synd_d      = synd_q;
        synd_zero_d = synd_zero_q;
        cw_len_d    = cw_len_q;
`ifdef RS_LEN_CHECK_EN
        len_err_d   = len_err_q;
`endif
        if (finalise & buf_free) begin
            synd_val_d  = 1'b1;
            synd_d      = fin_synd;
            synd_zero_d = fin_zero;
            cw_len_d    = fin_len;
`ifdef RS_LEN_CHECK_EN
            len_err_d   = fin_len_err;
`endif
        end

        frame_err_d = sop_hit & in_acc;
        overrun_d   = finalise & ~buf_free;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            len_q       <= '0;
            synd_q      <= '0;
            synd_val_q  <= 1'b0;
            synd_zero_q <= 1'b0;
            cw_len_q    <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef RS_LEN_CHECK_EN
            len_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            len_q       <= len_d;
            synd_q      <= synd_d;
            synd_val_q  <= synd_val_d;
            synd_zero_q <= synd_zero_d;
            cw_len_q    <= cw_len_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
`ifdef RS_LEN_CHECK_EN
            len_err_q   <= len_err_d;
`endif
        end
    end

    assign synd      = synd_q;
    assign synd_val  = synd_val_q;
    assign synd_zero = synd_zero_q;
    assign cw_len    = cw_len_q;
    assign busy      = (state_q == ST_ACC);
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
`ifdef RS_LEN_CHECK_EN
    assign len_err   = len_err_q;
`endif

endmodule

// File: tb/tb_rs_syndrome_par.sv
// Directed and randomized bench for rs_syndrome_par (default build, NSYM=8, FCR=1).
// Reference syndromes come from direct polynomial evaluation r(alpha^k).
module tb_rs_syndrome_par;

    localparam int NSYM = 8;
    localparam int FCR  = 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              din_val, din_sop, din_eop;
    logic [7:0]        din;
    logic              synd_val, synd_rdy;
    logic [NSYM*8-1:0] synd;
    logic              synd_zero;
    logic [8:0]        cw_len;
    logic              busy, frame_err, overrun;

    int checks = 0;
    int errors = 0;

    rs_syndrome_par #(.NSYM(NSYM), .FCR(FCR), .N_MAX(255)) dut (
        .clk       (clk),
        .rst       (rst),
        .din_val   (din_val),
        .din_sop   (din_sop),
        .din_eop   (din_eop),
        .din       (din),
        .synd_val  (synd_val),
        .synd_rdy  (synd_rdy),
        .synd      (synd),
        .synd_zero (synd_zero),
        .cw_len    (cw_len),
        .busy      (busy),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] gfm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        logic [7:0] x;
        r = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) r ^= x;
            x = x[7] ? ((x << 1) ^ 8'h1D) : (x << 1);
        end
        return r;
    endfunction

    // S_j = sum_i c_i * x^(n-1-i) with x = alpha^(FCR+j-1), first symbol highest degree.
    function automatic logic [63:0] model(input logic [7:0] q[$]);
        logic [63:0] res;
        logic [7:0]  x, s, pw;
        res = '0;
        for (int j = 0; j < NSYM; j++) begin
            x = 8'h01;
            for (int k = 0; k < FCR + j; k++) x = gfm(x, 8'h02);
            s  = 8'h00;
            pw = 8'h01;
            for (int i = q.size() - 1; i >= 0; i--) begin
                s ^= gfm(q[i], pw);
                pw = gfm(pw, x);
            end
            res[j*8 +: 8] = s;
        end
        return res;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic sym(input logic sop, input logic eop, input logic [7:0] d);
        din_val = 1'b1;
        din_sop = sop;
        din_eop = eop;
        din     = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        din_val = 1'b0;
        din_sop = 1'b0;
        din_eop = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] q[$]);
        for (int i = 0; i < q.size(); i++)
            sym(i == 0, i == q.size() - 1, q[i]);
        din_val = 1'b0;
        din_sop = 1'b0;
        din_eop = 1'b0;
    endtask

    task automatic rand_cw(output logic [7:0] q[$], input int len);
        q = {};
        for (int i = 0; i < len; i++) q.push_back(8'($urandom_range(0, 255)));
    endtask

    task automatic chk_result(input string tag, input logic [7:0] q[$]);
        logic [63:0] e;
        e = model(q);
        chk({tag, "_val"},  synd_val, 1'b1);
        chk({tag, "_synd"}, synd, e);
        chk({tag, "_zero"}, synd_zero, e == '0);
        chk({tag, "_len"},  cw_len, (q.size() > 511) ? 511 : q.size());
    endtask

    initial begin
        logic [7:0]  q[$];
        logic [7:0]  qa[$];
        logic [7:0]  qb[$];
        logic [63:0] held;

        rst = 1'b1; synd_rdy = 1'b1;
        din_val = 1'b0; din_sop = 1'b0; din_eop = 1'b0; din = 8'h00;
        #1;
        chk("rst_val", synd_val, 1'b0);
        chk("rst_synd", synd, 64'h0);
        chk("rst_zero", synd_zero, 1'b0);
        chk("rst_len", cw_len, 9'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_flags", {frame_err, overrun}, 2'b00);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        idle(1);

        // 255 zero symbols: all syndromes zero
        q = {};
        for (int i = 0; i < 255; i++) q.push_back(8'h00);
        sym(1'b1, 1'b0, 8'h00);
        chk("t1_busy", busy, 1'b1);
        for (int i = 1; i < 255; i++) sym(1'b0, i == 254, 8'h00);
        din_val = 1'b0;
        chk_result("t1", q);
        chk("t1_zero1", synd_zero, 1'b1);
        idle(1);
        chk("t1_drop", synd_val, 1'b0);

        // single-symbol codeword
        send('{8'h01});
        chk("t2_synd", synd, {NSYM{8'h01}});
        chk("t2_len", cw_len, 9'd1);
        chk("t2_zero", synd_zero, 1'b0);
        chk("t2_ferr", frame_err, 1'b0);
        idle(1);

        // r(x) = x
        send('{8'h01, 8'h00});
        chk("t3_s1", synd[7:0], 8'h02);
        chk("t3_s2", synd[15:8], 8'h04);
        chk("t3_s8", synd[63:56], 8'h1D);
        idle(1);

        // random back-to-back codewords with zero gap
        for (int n = 0; n < 8; n++) begin
            rand_cw(q, $urandom_range(1, 40));
            send(q);
            chk_result($sformatf("rnd%0d", n), q);
        end
        idle(1);
        chk("rnd_drop", synd_val, 1'b0);

        // length saturation
        rand_cw(q, 520);
        send(q);
        chk_result("sat", q);
        idle(1);

        // held result under back-pressure, overrun on second codeword
        synd_rdy = 1'b0;
        rand_cw(qa, 10);
        rand_cw(qb, 12);
        send(qa);
        chk_result("ovr_a", qa);
        held = synd;
        send(qb);
        chk("ovr_pulse", overrun, 1'b1);
        chk("ovr_hold", synd, held);
        chk("ovr_len", cw_len, 9'd10);
        idle(1);
        chk("ovr_end", overrun, 1'b0);
        chk("ovr_val", synd_val, 1'b1);
        synd_rdy = 1'b1;
        idle(1);
        chk("ovr_xfer", synd_val, 1'b0);

        // sop arriving mid-codeword restarts accumulation
        for (int i = 0; i < 100; i++) sym(i == 0, 1'b0, 8'($urandom_range(0, 255)));
        rand_cw(q, 51);
        sym(1'b1, 1'b0, q[0]);
        chk("ferr_pulse", frame_err, 1'b1);
        chk("ferr_busy", busy, 1'b1);
        for (int i = 1; i < 51; i++) begin
            sym(1'b0, i == 50, q[i]);
            if (i == 1) chk("ferr_end", frame_err, 1'b0);
        end
        din_val = 1'b0;
        chk_result("ferr", q);
        idle(1);

        // reset mid-codeword with a held result
        synd_rdy = 1'b0;
        rand_cw(q, 5);
        send(q);
        chk("mrst_pre", synd_val, 1'b1);
        for (int i = 0; i < 30; i++) sym(i == 0, 1'b0, 8'($urandom_range(1, 255)));
        rst = 1'b1;
        #1;
        chk("mrst_val", synd_val, 1'b0);
        chk("mrst_synd", synd, 64'h0);
        chk("mrst_len", cw_len, 9'd0);
        chk("mrst_busy", busy, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        synd_rdy = 1'b1;
        for (int i = 0; i < 5; i++) sym(1'b0, i == 4, 8'h5A);
        din_val = 1'b0;
        chk("mrst_ign_busy", busy, 1'b0);
        chk("mrst_ign_val", synd_val, 1'b0);
        rand_cw(q, 17);
        send(q);
        chk_result("mrst_new", q);
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
